// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming convolution engine.
package conv_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        COEF = 1'b1
    } conv_state_e;

    // Accumulator width that holds the exact sum of K*K signed pixel*coef products.
    function automatic int unsigned acc_w(input int unsigned data_w,
                                          input int unsigned coef_w,
                                          input int unsigned k);
        return data_w + coef_w + 1 + $clog2(k * k);
    endfunction

    // Clamp to the signed out_w range, then optionally clamp negatives to zero.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] value,
                                                   input int unsigned        out_w,
                                                   input logic               relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi) begin
            res = hi;
        end else if (value < lo) begin
            res = lo;
        end else begin
            res = value;
        end
        if (relu && (res < 0)) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_stream_if.sv
// Kernel-load, pixel-in and result-out signals of conv_stream.
interface conv_stream_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned OUT_W  = 16
) ();
    logic              relu_en;
    logic              coef_start;
    logic              coef_valid;
    logic [COEF_W-1:0] coef_data;
    logic              coef_busy;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic              m_last;

    modport master (
        output relu_en, coef_start, coef_valid, coef_data, s_valid, s_data, m_ready,
        input  coef_busy, s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  relu_en, coef_start, coef_valid, coef_data, s_valid, s_data, m_ready,
        output coef_busy, s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/line_buffer.sv
// One image row of delay: output is the word written DEPTH enables ago.
module line_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;

    // Read-before-write: the slot about to be overwritten holds the oldest word.
    assign data_o = mem_q[ptr_q];

    // Circular write pointer; storage clears on reset.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
        end else if (en_i) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end
endmodule

// File: rtl/conv_stream.sv
// Streaming KxK valid-mode convolution with run-time kernel load,
// two-stage multiply / sum+saturate pipeline and valid/ready flow control.
module conv_stream
    import conv_pkg::*;
#(
    parameter int unsigned K      = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic          clock,
    input  logic          nreset,
    conv_stream_if.slave  bus
);
    localparam int unsigned KK     = K * K;
    localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W, K);
    localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned IDX_W  = $clog2(KK);

    conv_state_e              state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [COEF_W-1:0] kernel_q [KK];
    logic [COL_W-1:0]         col_q;
    logic [ROW_W-1:0]         row_q;
    logic [DATA_W-1:0]        win_q [K][K];
    logic [DATA_W-1:0]        col_in [K];
    logic [DATA_W-1:0]        lb_out [K-1];
    logic                     win_vld_q, win_last_q, p1_vld_q, p1_last_q;
    logic signed [PROD_W-1:0] prod_q [KK];
    logic signed [PROD_W-1:0] prod_d [KK];
    logic signed [ACC_W-1:0]  acc;
    logic [OUT_W-1:0]         res_d;
    logic                     m_valid_q, m_last_q;
    logic [OUT_W-1:0]         m_data_q;
    logic                     adv, accept, frame_idle, col_end, row_end, win_hit;

    assign adv        = !m_valid_q || bus.m_ready;
    assign bus.s_ready = (state_q == RUN) && adv;
    assign accept     = bus.s_valid && bus.s_ready;
    assign col_end    = (col_q == COL_W'(IMG_W - 1));
    assign row_end    = (row_q == ROW_W'(IMG_H - 1));
    assign win_hit    = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));
    assign frame_idle = (col_q == '0) && (row_q == '0) && !win_vld_q && !p1_vld_q && !m_valid_q;

    assign bus.coef_busy = (state_q == COEF);
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_last    = m_last_q;

    // Newest window column: current pixel at the bottom, older rows from the line buffers.
    assign col_in[K-1] = bus.s_data;
    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        logic [DATA_W-1:0] lb_in;
        if (j == 0) begin : g_head
            assign lb_in = bus.s_data;
        end else begin : g_chain
            assign lb_in = lb_out[j-1];
        end
        line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (DATA_W)
        ) u_lb (
            .clock  (clock),
            .nreset (nreset),
            .en_i   (accept),
            .data_i (lb_in),
            .data_o (lb_out[j])
        );
        assign col_in[K-2-j] = lb_out[j];
    end

    // Mode FSM: kernel load only starts from a fully idle frame.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RUN: begin
                if (bus.coef_start && frame_idle) begin
                    state_d = COEF;
                end
            end
            COEF: begin
                if (bus.coef_valid) begin
                    if (idx_q == IDX_W'(KK - 1)) begin
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // FSM state and coefficient index registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= RUN;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Kernel storage, written in raster order during load.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < KK; i++) begin
                kernel_q[i] <= '0;
            end
        end else if ((state_q == COEF) && bus.coef_valid) begin
            kernel_q[idx_q] <= bus.coef_data;
        end
    end

    // Raster position of the next pixel.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Window shifts left one column per accepted pixel; win_q[0][0] is the top-left tap.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= col_in[r];
            end
        end
    end

    // Unsigned pixel times signed coefficient, one product per tap.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod_d[r*K+c] = PROD_W'($signed({1'b0, win_q[r][c]})) * PROD_W'(kernel_q[r*K+c]);
            end
        end
    end

    // Exact sum of products, then saturate and optional ReLU.
    always_comb begin
        acc = '0;
        for (int i = 0; i < KK; i++) begin
            acc = acc + ACC_W'(prod_q[i]);
        end
        res_d = OUT_W'(sat_relu(64'(acc), OUT_W, bus.relu_en));
    end

    // Window-valid flag, product stage and output stage all advance together.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
            p1_vld_q   <= 1'b0;
            p1_last_q  <= 1'b0;
            for (int i = 0; i < KK; i++) begin
                prod_q[i] <= '0;
            end
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (adv) begin
            win_vld_q  <= accept && win_hit;
            win_last_q <= accept && row_end && col_end;
            p1_vld_q   <= win_vld_q;
            p1_last_q  <= win_last_q;
            if (win_vld_q) begin
                prod_q <= prod_d;
            end
            m_valid_q <= p1_vld_q;
            if (p1_vld_q) begin
                m_data_q <= res_d;
                m_last_q <= p1_last_q;
            end
        end
    end
endmodule
